serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only when not busy.
REQ-005 Port: a  input  WIDTH  minuend, sampled with accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend, sampled with accepted start.
REQ-007 Port: borrow_in  input  1  incoming borrow, sampled with accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 Port: done  output  1  one-cycle pulse marking out/borrow_out updated.
REQ-010 Port: out  output  WIDTH  difference (a - b - borrow_in) mod 2^WIDTH.
REQ-011 Port: borrow_out  output  1  final borrow; high iff a < b + borrow_in (unsigned).

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; all outputs registered.
REQ-013 IDLE: start=1 SHALL latch a, b, borrow_in into internal registers, clear the bit counter, and go to SHIFT.
REQ-014 SHIFT: each cycle SHALL process one bit, LSB first: diff = a_i ^ b_i ^ brw; brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
REQ-015 Diff bits SHALL shift into an internal result register from the MSB end, so after WIDTH cycles bit 0 sits at position 0.
REQ-016 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE; out and borrow_out are loaded on that same edge.
REQ-017 Latency: done SHALL be high in the cycle following the (WIDTH+1)th rising edge after the edge that sampled start (WIDTH=4: start sampled at edge N, done visible after edge N+5).
REQ-018 done SHALL be high for exactly one cycle (DONE state); DONE then returns to IDLE.
REQ-019 start in the DONE cycle SHALL be accepted exactly as in IDLE (back-to-back operation, next state SHIFT).
REQ-020 start while busy SHALL be ignored; operands in flight are unaffected; a, b, borrow_in changes during SHIFT have no effect.
REQ-021 out and borrow_out SHALL hold their last loaded values until the next completion; they never show partial results.
REQ-022 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never wrap during an operation.

Reset
REQ-023 reset=1 SHALL force IDLE; busy=0, done=0, out=0, borrow_out=0, internal operand/result/borrow/counter registers=0.
REQ-024 reset SHALL take priority over start and over any in-flight operation; an aborted operation produces no done pulse.
REQ-025 First start after reset deassertion SHALL be accepted in the first cycle reset is low.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-027 The per-bit logic SHALL be a combinational sub-module full_subtractor (a, b, borrow_in, diff, borrow_out), instantiated once inside serial_subtractor.
REQ-028 No other sub-modules; datapath shift registers, borrow flop, counter and FSM live in serial_subtractor.

Verification (WIDTH=4)
REQ-029 a=9, b=3, borrow_in=0, start at edge N -> busy edges N+1..N+4, done one cycle after edge N+5, out=6, borrow_out=0.
REQ-030 a=3, b=9, borrow_in=0 -> out=0xA, borrow_out=1.
REQ-031 a=0, b=0, borrow_in=1 -> out=0xF, borrow_out=1; a=0xF, b=0xF, borrow_in=0 -> out=0, borrow_out=0.
REQ-032 start pulsed with a=1, b=1 on the 2nd busy cycle of a 9-3 operation -> ignored; single done, out=6.
REQ-033 reset asserted on 2nd SHIFT cycle -> next cycle busy=0, done=0, out=0, borrow_out=0; no done pulse follows.
REQ-034 start held high across DONE with a=7, b=2 -> second operation starts immediately, done pulses twice 5 cycles apart, out=6 then 5.
REQ-035 Exhaustive random check: all 512 (a, b, borrow_in) combinations match the reference model in REQ-010/REQ-011.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: diff = a - b - borrow_in, with outgoing borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per cycle, LSB first,
// and publishes the difference and final borrow when the whole word is done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] out_q;
  logic             brw_q;
  logic             borrow_out_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  logic             diff_d;
  logic             brw_d;
  logic [WIDTH-1:0] res_d;

  full_subtractor u_fs (
    .a          (a_q[0]),
    .b          (b_q[0]),
    .borrow_in  (brw_q),
    .diff       (diff_d),
    .borrow_out (brw_d)
  );

  // New diff bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  assign res_d = {diff_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      out_q        <= '0;
      brw_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      busy_q <= (state_q == SHIFT);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= borrow_in;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          brw_q <= brw_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            out_q        <= res_d;
            borrow_out_q <= brw_d;
            state_q      <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign out        = out_q;
  assign borrow_out = borrow_out_q;

endmodule
